// File: rtl/fixed_to_decimal_display.sv
`default_nettype none
// ============================================================================
// Module      : fixed_to_decimal_display
// Description : Converts a signed Q39.10 fixed-point value into BCD integer
//               and fractional digits with leading-zero blanking, sign,
//               overflow and error indications for a calculator display.
// Revision    : 1.0 - initial release
// ============================================================================
module fixed_to_decimal_display #(
    parameter int FRACTION_BITS = 10,
    parameter int INT_DIGITS    = 8,
    parameter int FRAC_DIGITS   = 3
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  start,
    input  logic [49:0]                           value_in,
    input  logic                                  error_in,
    output logic                                  busy,
    output logic                                  done,
    output logic [4*(INT_DIGITS+FRAC_DIGITS)-1:0] digits,
    output logic [INT_DIGITS-1:0]                 blank_mask,
    output logic                                  negative,
    output logic                                  overflow,
    output logic                                  error_out
);

    localparam int c_INT_W = 50 - FRACTION_BITS;
    localparam int c_FP_W  = FRACTION_BITS + 4;
    localparam int c_IDW   = 4 * INT_DIGITS;
    localparam int c_FDW   = 4 * FRAC_DIGITS;
    localparam int c_CNT_W = $clog2(INT_DIGITS + FRAC_DIGITS + 1);

    // Smallest integer part that no longer fits in INT_DIGITS decimal digits
    function automatic logic [63:0] pow10(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int k = 0; k < n; k++) p = p * 64'd10;
        return p;
    endfunction

    localparam logic [63:0]        c_INT_LIMIT = pow10(INT_DIGITS);
    localparam logic [c_CNT_W-1:0] c_INT_LAST  = c_CNT_W'(INT_DIGITS - 1);
    localparam logic [c_CNT_W-1:0] c_FRAC_LAST = c_CNT_W'(FRAC_DIGITS - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD      = 3'd1,
        INT_CONV  = 3'd2,
        FRAC_CONV = 3'd3,
        DONE      = 3'd4
    } state_t;

    state_t                     r_state;
    state_t                     w_state_next;
    logic [49:0]                r_value;
    logic [c_INT_W-1:0]         r_int;
    logic [FRACTION_BITS-1:0]   r_frac;
    logic [c_CNT_W-1:0]         r_cnt;
    logic [c_IDW-1:0]           r_int_acc;
    logic [c_FDW-1:0]           r_frac_acc;

    logic [49:0]                w_mag;
    logic                       w_int_ovf;
    logic [3:0]                 w_int_dig;
    logic [c_INT_W-1:0]         w_int_quot;
    logic [c_IDW-1:0]           w_int_acc_next;
    logic [c_FP_W-1:0]          w_frac_p;
    logic [c_FDW-1:0]           w_frac_acc_next;
    logic [c_IDW+c_FDW-1:0]     w_final;
    logic [INT_DIGITS-1:0]      w_blank;
    logic                       w_lead;

    // Magnitude of the captured value; -2^49 maps onto 2^49 in 50 unsigned bits
    assign w_mag     = r_value[49] ? (~r_value + 50'd1) : r_value;
    assign w_int_ovf = (64'(w_mag[49:FRACTION_BITS]) >= c_INT_LIMIT);

    // Integer digits come out LS first and shift down from the top nibble
    assign w_int_dig      = 4'(r_int % c_INT_W'(10));
    assign w_int_quot     = r_int / c_INT_W'(10);
    assign w_int_acc_next = (r_int_acc >> 4) | (c_IDW'(w_int_dig) << (c_IDW - 4));

    // Fractional digits come out MS first and shift up from the bottom nibble
    assign w_frac_p        = {4'b0000, r_frac} * c_FP_W'(10);
    assign w_frac_acc_next = (r_frac_acc << 4) | c_FDW'(w_frac_p[c_FP_W-1:FRACTION_BITS]);
    assign w_final         = {r_int_acc, w_frac_acc_next};

    // Leading-zero blanking: digit i blanks when it and every digit above are zero
    always_comb begin
        w_blank = '0;
        w_lead  = 1'b1;
        for (int i = INT_DIGITS - 1; i >= 1; i--) begin
            w_lead     = w_lead & (r_int_acc[4*i +: 4] == 4'd0);
            w_blank[i] = w_lead;
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_state_next;
    end

    // Next-state decode and status outputs
    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) w_state_next = error_in ? DONE : LOAD;
            end
            LOAD: begin
                busy         = 1'b1;
                w_state_next = w_int_ovf ? DONE : INT_CONV;
            end
            INT_CONV: begin
                busy = 1'b1;
                if (r_cnt == c_INT_LAST) w_state_next = FRAC_CONV;
            end
            FRAC_CONV: begin
                busy = 1'b1;
                if (r_cnt == c_FRAC_LAST) w_state_next = DONE;
            end
            DONE: begin
                done         = 1'b1;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Datapath: capture, digit extraction and result registers that change only entering DONE
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_value    <= '0;
            r_int      <= '0;
            r_frac     <= '0;
            r_cnt      <= '0;
            r_int_acc  <= '0;
            r_frac_acc <= '0;
            digits     <= '0;
            blank_mask <= '0;
            negative   <= 1'b0;
            overflow   <= 1'b0;
            error_out  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_value <= value_in;
                        if (error_in) begin
                            digits     <= '0;
                            blank_mask <= '0;
                            negative   <= 1'b0;
                            overflow   <= 1'b0;
                            error_out  <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    r_int  <= w_mag[49:FRACTION_BITS];
                    r_frac <= w_mag[FRACTION_BITS-1:0];
                    r_cnt  <= '0;
                    if (w_int_ovf) begin
                        digits     <= '0;
                        blank_mask <= '0;
                        negative   <= r_value[49];
                        overflow   <= 1'b1;
                        error_out  <= 1'b0;
                    end
                end
                INT_CONV: begin
                    r_int     <= w_int_quot;
                    r_int_acc <= w_int_acc_next;
                    r_cnt     <= (r_cnt == c_INT_LAST) ? '0 : r_cnt + 1'b1;
                end
                FRAC_CONV: begin
                    r_frac     <= w_frac_p[FRACTION_BITS-1:0];
                    r_frac_acc <= w_frac_acc_next;
                    r_cnt      <= r_cnt + 1'b1;
                    if (r_cnt == c_FRAC_LAST) begin
                        digits     <= w_final;
                        blank_mask <= w_blank;
                        negative   <= r_value[49] & (|w_final);
                        overflow   <= 1'b0;
                        error_out  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fixed_to_decimal_display.sv
`default_nettype none
// ============================================================================
// Module      : tb_fixed_to_decimal_display
// Description : Directed self-checking bench for fixed_to_decimal_display
//               with an arithmetic reference model and a per-cycle monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fixed_to_decimal_display;

    logic        clk;
    logic        reset;
    logic        start;
    logic [49:0] value_in;
    logic        error_in;
    logic        busy;
    logic        done;
    logic [43:0] digits;
    logic [7:0]  blank_mask;
    logic        negative;
    logic        overflow;
    logic        error_out;

    int checks;
    int errors;
    int done_count;
    int dc0;

    // Model expectations for the conversion in flight
    logic [43:0] m_digits;
    logic [7:0]  m_blank;
    logic        m_neg, m_ovf, m_err;
    int          m_lat;

    // Values the held outputs must show right now
    logic [43:0] h_digits;
    logic [7:0]  h_blank;
    logic        h_neg, h_ovf, h_err;

    fixed_to_decimal_display dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .value_in   (value_in),
        .error_in   (error_in),
        .busy       (busy),
        .done       (done),
        .digits     (digits),
        .blank_mask (blank_mask),
        .negative   (negative),
        .overflow   (overflow),
        .error_out  (error_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Decimal rendering of a Q39.10 value using plain integer arithmetic
    function automatic void model_set(input logic [49:0] v, input bit err);
        longint s, mag, ip, fd, pw;
        s   = longint'($signed(v));
        mag = (s < 0) ? -s : s;
        ip  = mag / 1024;
        fd  = ((mag % 1024) * 1000) / 1024;
        m_digits = '0;
        m_blank  = '0;
        m_neg    = 1'b0;
        m_ovf    = 1'b0;
        m_err    = 1'b0;
        if (err) begin
            m_err = 1'b1;
            m_lat = 1;
        end else if (ip >= 64'd100000000) begin
            m_ovf = 1'b1;
            m_neg = (s < 0);
            m_lat = 2;
        end else begin
            pw = 1;
            for (int k = 0; k < 8; k++) begin
                m_digits[4*(k+3) +: 4] = 4'((ip / pw) % 10);
                if (k > 0) m_blank[k] = (ip < pw);
                pw = pw * 10;
            end
            m_digits[0 +: 4] = 4'(fd % 10);
            m_digits[4 +: 4] = 4'((fd / 10) % 10);
            m_digits[8 +: 4] = 4'(fd / 100);
            m_neg = (s < 0) && (ip != 0 || fd != 0);
            m_lat = 13;
        end
    endfunction

    // Per-cycle monitor: held outputs must match the last completed result
    always @(negedge clk) begin
        if (!reset) begin
            h_digits = '0; h_blank = '0; h_neg = 1'b0; h_ovf = 1'b0; h_err = 1'b0;
        end else if (done) begin
            h_digits = m_digits; h_blank = m_blank; h_neg = m_neg; h_ovf = m_ovf; h_err = m_err;
            done_count++;
        end
        chk("mon_digits", digits, h_digits);
        chk("mon_blank", blank_mask, h_blank);
        chk("mon_negative", negative, h_neg);
        chk("mon_overflow", overflow, h_ovf);
        chk("mon_error", error_out, h_err);
        chk("mon_busy_done_excl", busy & done, 0);
    end

    task automatic convert(input logic [49:0] v, input bit err, input bit poke);
        int lat;
        int d0;
        model_set(v, err);
        @(negedge clk);
        value_in = v; error_in = err; start = 1'b1;
        d0 = done_count;
        @(negedge clk);
        start = 1'b0; error_in = 1'b0; value_in = ~v;
        lat = 1;
        while (!done && lat < 40) begin
            chk("busy_during", busy, 1);
            if (poke && lat == 3) begin start = 1'b1; error_in = 1'b1; end
            else begin start = 1'b0; error_in = 1'b0; end
            @(negedge clk);
            lat++;
        end
        start = 1'b0; error_in = 1'b0;
        chk("latency", lat, m_lat);
        chk("busy_at_done", busy, 0);
        @(negedge clk);
        chk("done_one_cycle", done, 0);
        if (poke) repeat (16) @(negedge clk);
        chk("done_count", done_count - d0, 1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_digits"}, digits, 0);
        chk({tag, "_blank"}, blank_mask, 0);
        chk({tag, "_negative"}, negative, 0);
        chk({tag, "_overflow"}, overflow, 0);
        chk({tag, "_error"}, error_out, 0);
    endtask

    initial begin
        checks = 0; errors = 0; done_count = 0;
        reset = 1'b1; start = 1'b0; value_in = '0; error_in = 1'b0;
        #1 reset = 1'b0;
        #1 chk_all_zero("reset");
        repeat (3) @(negedge clk);
        reset = 1'b1;

        convert(50'd3584, 1'b0, 1'b0);
        chk("lit_3p5_digits", digits, 44'h00000003500);
        chk("lit_3p5_blank", blank_mask, 8'hFE);
        chk("lit_3p5_neg", negative, 0);

        convert(-50'sd12544, 1'b0, 1'b0);
        chk("lit_m12p25_digits", digits, 44'h00000012250);
        chk("lit_m12p25_blank", blank_mask, 8'hFC);
        chk("lit_m12p25_neg", negative, 1);

        convert(50'd102, 1'b0, 1'b0);
        chk("lit_trunc_digits", digits, 44'h00000000099);

        convert({50{1'b1}}, 1'b0, 1'b0);
        chk("lit_m1_digits", digits, 44'h0);
        chk("lit_m1_neg", negative, 0);
        chk("lit_m1_blank", blank_mask, 8'hFE);

        convert(50'd99999999 << 10, 1'b0, 1'b0);
        chk("lit_max_digits", digits, 44'h99999999000);
        chk("lit_max_blank", blank_mask, 8'h00);
        chk("lit_max_ovf", overflow, 0);

        convert(50'd100000000 << 10, 1'b0, 1'b0);
        chk("lit_ovf_flag", overflow, 1);
        chk("lit_ovf_digits", digits, 44'h0);
        chk("lit_ovf_neg", negative, 0);

        convert({1'b1, 49'b0}, 1'b0, 1'b0);
        chk("lit_minneg_ovf", overflow, 1);
        chk("lit_minneg_neg", negative, 1);

        convert(-50'sd5120, 1'b1, 1'b0);
        chk("lit_err_flag", error_out, 1);
        chk("lit_err_ovf", overflow, 0);
        chk("lit_err_neg", negative, 0);
        chk("lit_err_digits", digits, 44'h0);

        convert((50'd12345678 << 10) | 50'd1023, 1'b0, 1'b1);
        convert(-50'sd512, 1'b0, 1'b0);
        convert(50'd1, 1'b0, 1'b0);

        // Abort a conversion with reset while in the integer phase
        model_set(50'd3584, 1'b0);
        @(negedge clk);
        value_in = 50'd3584; start = 1'b1;
        dc0 = done_count;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_reset_busy", busy, 1);
        #2 reset = 1'b0;
        #1 chk_all_zero("abort");
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (16) @(negedge clk);
        chk("abort_no_done", done_count - dc0, 0);

        convert(50'd3584, 1'b0, 1'b0);
        chk("lit_after_abort_digits", digits, 44'h00000003500);
        chk("lit_after_abort_blank", blank_mask, 8'hFE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
